ecc_scrub_ctrl: RTL and testbench
=================================

# ecc_scrub_ctrl

Control and reporting stage for the ECC output scrubber. It paces the scrubber with a programmable trigger interval and tracks the row address the scrubber is currently on. It also consumes the scrubber's per-row error strobes: counting correctable and uncorrectable events, capturing the address and bank of the first uncorrectable error, and raising a sticky interrupt. It sits beside the scrubber in the ECC SRAM wrapper, upstream on `scrub_trigger` and downstream on the `scrub_*` result strobes.

## Interface
Parameters:
- `Depth`, 2048: data-bank rows the scrubber walks; the address mirror wraps at `Depth`.
- `AddrWidth`, `$clog2(Depth)`: width of the row address.
- `IntervalWidth`, 16: width of the trigger interval counter.
- `CntWidth`, 16: width of each saturating error counter.

Ports:
- `clk_i`  in  1  clock. One clock domain; all logic is on the rising edge.
- `rst_i`  in  1  reset. Synchronous and active-high.
- `cfg_enable_i`  in  1  scrubbing enable.
- `cfg_interval_i`  in  IntervalWidth  idle cycles between the end of one row and the next trigger.
- `clr_i`  in  1  clears counters, the capture and `irq_o`.
- `scrub_trigger_o`  out  1  drives the scrubber trigger input.
- `scrub_done_i`  in  1  one-cycle strobe from the scrubber in its Check state, meaning a row has finished.
- `scrub_tag_bit_corrected_i`  in  1  tag single error on the finished row.
- `scrub_tag_uncorrectable_i`  in  1  tag multi error on the finished row.
- `scrub_data_bit_corrected_i`  in  1  data single error on the finished row.
- `scrub_data_uncorrectable_i`  in  1  data multi error on the finished row.
- `row_o`  out  AddrWidth  address of the next row to be scrubbed.
- `sweep_done_o`  out  1  one-cycle pulse when the row address wraps.
- `corr_cnt_o`  out  CntWidth  count of correctable events, saturating.
- `uncorr_cnt_o`  out  CntWidth  count of uncorrectable events, saturating.
- `err_valid_o`  out  1  an uncorrectable error has been captured.
- `err_addr_o`  out  AddrWidth  row of the captured error.
- `err_tag_o`  out  1  the captured error includes the tag bank.
- `err_data_o`  out  1  the captured error includes the data bank.
- `err_overflow_o`  out  1  another uncorrectable error arrived while `err_valid_o` was set.
- `irq_o`  out  1  equals `err_valid_o`.

## Operation
Trigger FSM has three states: Off, Count and Req.
- Off: `scrub_trigger_o`=0 and the interval counter is held at 0. If `cfg_enable_i`=1, go to Count.
- Count: the interval counter increments every cycle.
  - When the counter equals `cfg_interval_i`, clear the counter and go to Req.
  - An interval of 0 therefore spends exactly one cycle in Count.
  - If `cfg_enable_i`=0, go to Off.
- Req: `scrub_trigger_o`=1, registered so that it equals (state==Req).
  - On `scrub_done_i`=1, go to Count. The trigger drops the next cycle, so the scrubber, now back in Idle, starts exactly one row per request.
  - If `cfg_enable_i`=0, go to Off immediately. A row already accepted by the scrubber still completes, and its `scrub_done_i` is processed normally.

Row address mirror (`row_q`):
- On each `scrub_done_i`, `row_q` increments.
- When `row_q`==`Depth`-1, it wraps to 0 and `sweep_done_o` pulses in the following cycle.
- `row_q` is independent of FSM state.
- `clr_i` does not reset `row_q`.

Error strobes are qualified by `scrub_done_i`; any strobe without done is ignored.

Counters:
- `corr_cnt_o` adds the number of corrected strobes set (0, 1 or 2) and saturates at 2^CntWidth-1.
- `uncorr_cnt_o` does the same for the uncorrectable strobes.

Capture:
- The first qualified uncorrectable event with `err_valid_o`=0 loads `err_addr_o`=`row_q` (the row just finished), `err_tag_o` and `err_data_o`, and sets `err_valid_o`.
- Later uncorrectable events leave the capture unchanged and set `err_overflow_o`.

`clr_i`:
- Zeroes both counters, `err_valid_o`, `err_overflow_o`, the capture fields and `irq_o`.
- If an event arrives in the same cycle as `clr_i`, it is applied on top of the cleared state: counters equal that cycle's increment and the capture loads. The clear never drops an event.

## Timing
- All outputs are registered.
- Reset value of every output is 0; the FSM resets to Off.
- Outputs update one cycle after the causing input edge:
  - `scrub_trigger_o` rises one cycle after Count reaches the interval, and falls one cycle after `scrub_done_i`.
  - Counters, capture and `irq_o` update one cycle after `scrub_done_i`.
  - `row_o` updates one cycle after `scrub_done_i`.
- Row period: from done to the next trigger rise is `cfg_interval_i`+1 cycles, plus scrubber arbitration time.
- `rst_i` asserted mid-row: all state returns to reset values. A done strobe from the scrubber during reset is ignored.
- Changing `cfg_interval_i` during Count takes effect at the next comparison. If the new value is below the current count, the counter runs until it wraps at 2^IntervalWidth.

## Test plan
- Reset, enable, interval=3, scrubber model finishing 2 cycles after trigger -> trigger high 2 cycles, low 4 cycles between rows; `row_o` steps 0,1,2.
- `Depth`=4, run 5 rows -> `row_o` goes 3->0, `sweep_done_o` pulses once, one cycle after the 4th done.
- Done with tag and data corrected together at row 5 -> `corr_cnt_o`=2; uncorrectable data at row 7 -> `err_valid_o`=1, `err_addr_o`=7, `err_data_o`=1, `err_tag_o`=0, `irq_o`=1.
- Second uncorrectable at row 9 -> capture still 7, `err_overflow_o`=1; `clr_i` in the same cycle as a tag-uncorrectable done at row 10 -> `uncorr_cnt_o`=1, `err_addr_o`=10, `err_tag_o`=1, `err_overflow_o`=0.
- `CntWidth`=2, six corrected events -> `corr_cnt_o` saturates at 3; corrected strobe without done -> no change.
- Disable in Req -> trigger falls next cycle and the FSM is in Off; the late done still advances `row_o`; `rst_i` mid-Req -> all outputs 0.

Source files
------------

// File: rtl/ecc_scrub_ctrl.sv
// ECC scrub controller: paces the scrubber trigger, mirrors its row address,
// and accumulates per-row error strobes into saturating counters and a first-error capture.
module ecc_scrub_ctrl #(
  parameter int unsigned Depth         = 2048,
  parameter int unsigned AddrWidth     = $clog2(Depth),
  parameter int unsigned IntervalWidth = 16,
  parameter int unsigned CntWidth      = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cfg_enable_i,
  input  logic [IntervalWidth-1:0] cfg_interval_i,
  input  logic                     clr_i,
  output logic                     scrub_trigger_o,
  input  logic                     scrub_done_i,
  input  logic                     scrub_tag_bit_corrected_i,
  input  logic                     scrub_tag_uncorrectable_i,
  input  logic                     scrub_data_bit_corrected_i,
  input  logic                     scrub_data_uncorrectable_i,
  output logic [AddrWidth-1:0]     row_o,
  output logic                     sweep_done_o,
  output logic [CntWidth-1:0]      corr_cnt_o,
  output logic [CntWidth-1:0]      uncorr_cnt_o,
  output logic                     err_valid_o,
  output logic [AddrWidth-1:0]     err_addr_o,
  output logic                     err_tag_o,
  output logic                     err_data_o,
  output logic                     err_overflow_o,
  output logic                     irq_o
);

  localparam logic [1:0] StOff   = 2'd0;
  localparam logic [1:0] StCount = 2'd1;
  localparam logic [1:0] StReq   = 2'd2;

  localparam int unsigned SumW = CntWidth + 1;

  function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] a,
                                                  input logic [1:0] inc);
    logic [CntWidth:0] s;
    s = {1'b0, a} + SumW'(inc);
    return s[CntWidth] ? '1 : s[CntWidth-1:0];
  endfunction

  logic [1:0]               state_q, state_d;
  logic [IntervalWidth-1:0] ivl_q, ivl_d;
  logic                     trig_q;
  logic [AddrWidth-1:0]     row_q, row_d;
  logic                     sweep_q, sweep_d;
  logic [CntWidth-1:0]      corr_q, corr_d, uncorr_q, uncorr_d;
  logic                     valid_q, valid_d, ovf_q, ovf_d;
  logic [AddrWidth-1:0]     addr_q, addr_d;
  logic                     tag_q, tag_d, data_q, data_d;
  logic                     last_row, unc_evt;
  logic [1:0]               corr_inc, uncorr_inc;

  always_comb begin
    state_d = state_q;
    ivl_d   = ivl_q;
    unique case (state_q)
      StOff: begin
        ivl_d = '0;
        if (cfg_enable_i) state_d = StCount;
      end
      StCount: begin
        if (!cfg_enable_i) begin
          state_d = StOff;
          ivl_d   = '0;
        end else if (ivl_q == cfg_interval_i) begin
          state_d = StReq;
          ivl_d   = '0;
        end else begin
          ivl_d = ivl_q + IntervalWidth'(1);
        end
      end
      StReq: begin
        ivl_d = '0;
        if (!cfg_enable_i)     state_d = StOff;
        else if (scrub_done_i) state_d = StCount;
      end
      default: begin
        state_d = StOff;
        ivl_d   = '0;
      end
    endcase
  end

  assign last_row = (row_q == AddrWidth'(Depth - 1));

  always_comb begin
    row_d   = row_q;
    sweep_d = 1'b0;
    if (scrub_done_i) begin
      row_d   = last_row ? '0 : row_q + AddrWidth'(1);
      sweep_d = last_row;
    end
  end

  // Clear is applied first so a same-cycle event lands on the cleared state.
  always_comb begin
    corr_inc   = scrub_done_i ? ({1'b0, scrub_tag_bit_corrected_i} + {1'b0, scrub_data_bit_corrected_i}) : 2'd0;
    uncorr_inc = scrub_done_i ? ({1'b0, scrub_tag_uncorrectable_i} + {1'b0, scrub_data_uncorrectable_i}) : 2'd0;
    unc_evt    = scrub_done_i & (scrub_tag_uncorrectable_i | scrub_data_uncorrectable_i);
    corr_d     = sat_add(clr_i ? '0 : corr_q, corr_inc);
    uncorr_d   = sat_add(clr_i ? '0 : uncorr_q, uncorr_inc);
    valid_d    = clr_i ? 1'b0 : valid_q;
    ovf_d      = clr_i ? 1'b0 : ovf_q;
    addr_d     = clr_i ? '0 : addr_q;
    tag_d      = clr_i ? 1'b0 : tag_q;
    data_d     = clr_i ? 1'b0 : data_q;
    if (unc_evt) begin
      if (!valid_d) begin
        valid_d = 1'b1;
        addr_d  = row_q;
        tag_d   = scrub_tag_uncorrectable_i;
        data_d  = scrub_data_uncorrectable_i;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StOff;
      ivl_q    <= '0;
      trig_q   <= 1'b0;
      row_q    <= '0;
      sweep_q  <= 1'b0;
      corr_q   <= '0;
      uncorr_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      addr_q   <= '0;
      tag_q    <= 1'b0;
      data_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ivl_q    <= ivl_d;
      trig_q   <= (state_d == StReq);
      row_q    <= row_d;
      sweep_q  <= sweep_d;
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      addr_q   <= addr_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
    end
  end

  assign scrub_trigger_o = trig_q;
  assign row_o           = row_q;
  assign sweep_done_o    = sweep_q;
  assign corr_cnt_o      = corr_q;
  assign uncorr_cnt_o    = uncorr_q;
  assign err_valid_o     = valid_q;
  assign err_addr_o      = addr_q;
  assign err_tag_o       = tag_q;
  assign err_data_o      = data_q;
  assign err_overflow_o  = ovf_q;
  assign irq_o           = valid_q;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Scoreboard bench for ecc_scrub_ctrl: a stimulus process drives rows through a scrubber
// model and queues expected status; a negedge monitor pops and compares.
module tb_ecc_scrub_ctrl;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int IW    = 16;
  localparam int CW    = 3;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1, cfg_enable_i = 1'b0, clr_i = 1'b0;
  logic [IW-1:0] cfg_interval_i = '0;
  logic          scrub_done_i = 1'b0;
  logic          tc_i = 1'b0, tu_i = 1'b0, dc_i = 1'b0, du_i = 1'b0;
  logic          trig_o, sweep_o, valid_o, tag_o, data_o, ovf_o, irq_o;
  logic [AW-1:0] row_o, addr_o;
  logic [CW-1:0] corr_o, uncorr_o;

  ecc_scrub_ctrl #(.Depth(DEPTH), .AddrWidth(AW), .IntervalWidth(IW), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .cfg_enable_i(cfg_enable_i), .cfg_interval_i(cfg_interval_i),
    .clr_i(clr_i), .scrub_trigger_o(trig_o), .scrub_done_i(scrub_done_i),
    .scrub_tag_bit_corrected_i(tc_i), .scrub_tag_uncorrectable_i(tu_i),
    .scrub_data_bit_corrected_i(dc_i), .scrub_data_uncorrectable_i(du_i),
    .row_o(row_o), .sweep_done_o(sweep_o), .corr_cnt_o(corr_o), .uncorr_cnt_o(uncorr_o),
    .err_valid_o(valid_o), .err_addr_o(addr_o), .err_tag_o(tag_o), .err_data_o(data_o),
    .err_overflow_o(ovf_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due; int row; int sweep; int corr; int uncorr;
    int valid; int addr; int tag; int data; int ovf;
    bit chk_trig; int trig;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference state
  int m_row, m_sweep, m_corr, m_uncorr, m_valid, m_addr, m_tag, m_data, m_ovf;
  bit rst_v, en_v, noisy;

  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.due < cyc) begin
        checks++; errors++;
        $display("FAIL stale_entry cycle %0d: got due %0d expected %0d", cyc, e.due, cyc);
      end else begin
        chk("row", row_o, e.row);
        chk("sweep", sweep_o, e.sweep);
        chk("corr_cnt", corr_o, e.corr);
        chk("uncorr_cnt", uncorr_o, e.uncorr);
        chk("err_valid", valid_o, e.valid);
        chk("irq", irq_o, e.valid);
        chk("err_addr", addr_o, e.addr);
        chk("err_tag", tag_o, e.tag);
        chk("err_data", data_o, e.data);
        chk("err_overflow", ovf_o, e.ovf);
        if (e.chk_trig) chk("trigger", trig_o, e.trig);
      end
    end
  end

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // One clock: drive inputs, advance the reference model, queue what must be visible next cycle.
  task automatic step(input bit done, input bit [3:0] st, input bit clr, input bit ct, input bit et);
    exp_t e;
    rst_i = rst_v; cfg_enable_i = en_v; scrub_done_i = done; clr_i = clr;
    {du_i, dc_i, tu_i, tc_i} = st;
    if (rst_v) begin
      {m_row, m_sweep, m_corr, m_uncorr, m_valid, m_addr, m_tag, m_data, m_ovf} = '0;
    end else begin
      m_sweep = 0;
      if (clr) begin
        m_corr = 0; m_uncorr = 0; m_valid = 0; m_ovf = 0; m_addr = 0; m_tag = 0; m_data = 0;
      end
      if (done) begin
        m_corr   = min_i(m_corr + int'(st[0]) + int'(st[2]), CMAX);
        m_uncorr = min_i(m_uncorr + int'(st[1]) + int'(st[3]), CMAX);
        if (st[1] || st[3]) begin
          if (m_valid == 0) begin
            m_valid = 1; m_addr = m_row; m_tag = int'(st[1]); m_data = int'(st[3]);
          end else m_ovf = 1;
        end
        m_row   = (m_row + 1) % DEPTH;
        m_sweep = (m_row == 0) ? 1 : 0;
      end
    end
    e = '{cyc + 1, m_row, m_sweep, m_corr, m_uncorr, m_valid, m_addr, m_tag, m_data, m_ovf, ct, int'(et)};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic gap_step(input bit et);
    bit clr;
    bit [3:0] st;
    clr = noisy && ($urandom_range(0, 15) == 0);
    st  = noisy ? 4'($urandom_range(0, 15)) : 4'd0;
    step(1'b0, st, clr, 1'b1, et);
  endtask

  // Called right after a kick (enable rise or done): idle interval, request, scrubber latency, done.
  task automatic run_row(input int ivl, input int lat, input bit [3:0] st, input bit clr_done);
    cfg_interval_i = IW'(ivl);
    repeat (ivl) gap_step(1'b0);
    gap_step(1'b1);
    repeat (lat) gap_step(1'b1);
    step(1'b1, st, clr_done, 1'b1, 1'b0);
  endtask

  initial begin
    bit [3:0] st;
    rst_v = 1; en_v = 0; noisy = 0;
    repeat (3) step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    rst_v = 0;
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

    // Directed sweep: interval 3, scrubber answers one cycle into the request.
    cfg_interval_i = 3;
    en_v = 1;
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int r = 0; r < DEPTH; r++) begin
      case (r)
        5:       st = 4'b0101;
        7:       st = 4'b1000;
        9:       st = 4'b1000;
        10:      st = 4'b0010;
        default: st = 4'b0000;
      endcase
      run_row(3, 1, st, r == 10);
    end

    // Randomized rows with noise on clr and stray strobes between dones.
    noisy = 1;
    for (int r = 0; r < 200; r++)
      run_row($urandom_range(0, 5), $urandom_range(0, 3), 4'($urandom_range(0, 15)),
              $urandom_range(0, 7) == 0);
    noisy = 0;

    // Disable while requesting; the accepted row still completes.
    cfg_interval_i = 2;
    repeat (2) gap_step(1'b0);
    gap_step(1'b1);
    en_v = 0;
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'b0001, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

    // Re-enable, then reset in the middle of a request.
    en_v = 1;
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    cfg_interval_i = 1;
    gap_step(1'b0);
    gap_step(1'b1);
    rst_v = 1; en_v = 0;
    step(1'b1, 4'b1111, 1'b0, 1'b1, 1'b0);
    rst_v = 0;
    repeat (3) step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    en_v = 1;
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) run_row(0, 0, 4'b0100, 1'b0);
    en_v = 0;
    repeat (4) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
